eth_pcs_rx_block_sync: RTL

Clause 49 block-lock state machine for the 10GBASE-R PCS receive path. Sits directly downstream of the RX gearbox: it inspects the 2-bit sync header of every recovered 66-bit block, declares and maintains block lock, and issues a one-cycle slip request back to the gearbox until header alignment is found. Its lock status gates the descrambler and decoder.

---
 rtl/eth_pcs_params.sv | 13 +
 rtl/eth_pcs_rx_block_sync.sv | 77 +++++++
 2 files changed

// File: rtl/eth_pcs_params.sv
// eth_pcs_params: shared 10GBASE-R PCS constants and the block-sync state type
package eth_pcs_params;
  localparam int W_SYNC = 2;
  localparam logic [W_SYNC-1:0] SYNC_DATA = 2'b01;
  localparam logic [W_SYNC-1:0] SYNC_CTRL = 2'b10;
  localparam int SH_VAL_TH = 64;
  localparam int SH_INVAL_TH = 16;
  localparam int W_SH_VAL_TH = $clog2(SH_VAL_TH);
  localparam int W_SH_INVAL_TH = $clog2(SH_INVAL_TH);
  localparam int SLIP_HOLDOFF = 2;
  localparam int W_SLIP_HOLDOFF = SLIP_HOLDOFF > 1 ? $clog2(SLIP_HOLDOFF) : 1;
  typedef enum logic [1:0] {TEST, SLIP, HOLD} rx_bs_state_t;
endpackage

// File: rtl/eth_pcs_rx_block_sync.sv
// eth_pcs_rx_block_sync: sync-header block lock FSM issuing gearbox slip requests
module eth_pcs_rx_block_sync
  import eth_pcs_params::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [W_SYNC-1:0] i_sync,
  output logic              o_slip,
  output logic              o_block_lock,
  output logic              o_sh_invalid
);
  rx_bs_state_t state, state_n;
  logic [W_SH_VAL_TH-1:0] sh_cnt, sh_cnt_n;
  logic [W_SH_INVAL_TH-1:0] sh_inval_cnt, sh_inval_cnt_n;
  logic [W_SLIP_HOLDOFF-1:0] hold_cnt, hold_cnt_n;
  logic lock_n;
  logic sh_ok, win_end, bad, drop, hold_done;
  assign sh_ok = i_sync == SYNC_DATA || i_sync == SYNC_CTRL;
  assign win_end = sh_cnt == W_SH_VAL_TH'(SH_VAL_TH - 1);
  assign bad = state == TEST && i_valid && !sh_ok;
  assign drop = bad && (!o_block_lock || sh_inval_cnt == W_SH_INVAL_TH'(SH_INVAL_TH - 1));
  assign hold_done = SLIP_HOLDOFF == 0 || (i_valid && hold_cnt == W_SLIP_HOLDOFF'(SLIP_HOLDOFF - 1));
  always_comb begin
    state_n = state;
    sh_cnt_n = sh_cnt;
    sh_inval_cnt_n = sh_inval_cnt;
    hold_cnt_n = hold_cnt;
    lock_n = o_block_lock;
    unique case (state)
      TEST: if (i_valid) begin
        if (drop) begin
          state_n = SLIP;
          lock_n = 1'b0;
        end else if (win_end) begin
          sh_cnt_n = '0;
          sh_inval_cnt_n = '0;
          lock_n = 1'b1;
        end else begin
          sh_cnt_n = sh_cnt + 1'b1;
          sh_inval_cnt_n = sh_inval_cnt + W_SH_INVAL_TH'(!sh_ok);
        end
      end
      SLIP: begin
        state_n = HOLD;
        sh_cnt_n = '0;
        sh_inval_cnt_n = '0;
        hold_cnt_n = '0;
        lock_n = 1'b0;
      end
      HOLD: begin
        state_n = hold_done ? TEST : HOLD;
        hold_cnt_n = hold_done ? '0 : hold_cnt + W_SLIP_HOLDOFF'(i_valid);
      end
      default: state_n = TEST;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= TEST;
      sh_cnt <= '0;
      sh_inval_cnt <= '0;
      hold_cnt <= '0;
      o_block_lock <= 1'b0;
      o_slip <= 1'b0;
      o_sh_invalid <= 1'b0;
    end else begin
      state <= state_n;
      sh_cnt <= sh_cnt_n;
      sh_inval_cnt <= sh_inval_cnt_n;
      hold_cnt <= hold_cnt_n;
      o_block_lock <= lock_n;
      o_slip <= state == SLIP;
      o_sh_invalid <= bad;
    end
  end
endmodule
